// File: rtl/volo_spi_slave_regs.sv
// ----------------------------------------------------------------------------
// volo_spi_slave_regs
//   SPI mode-0 responder in front of a 2^ADDR_W x DATA_W register file.
//   Frame (MSB first, CS low): 1 R/W bit (1 = write), ADDR_W address bits,
//   DATA_W data bits. Every SPI pin is oversampled in the sys_clk domain;
//   nothing is clocked by SCLK. A local host port reads/writes the same
//   registers with a registered, 1-cycle-latency read path.
//
// Ports
//   sys_clk, reset       system clock, synchronous active-high reset
//   spi_cs/sclk/mosi     asynchronous SPI inputs (CS active low, SCLK idles low)
//   spi_miso             registered serial data out (0 outside the data phase)
//   spi_miso_oe          MISO output enable, high while synchronized CS is low
//   wr_strobe            1-cycle pulse when an SPI write is committed
//   wr_addr, wr_data     address/data of the last committed SPI write
//   frame_abort          1-cycle pulse when CS rises before a full frame
//   host_addr/we/wdata   local register access
//   host_rdata           regs[host_addr], registered
// ----------------------------------------------------------------------------
module volo_spi_slave_regs #(
    parameter int                ADDR_W      = 7,
    parameter int                DATA_W      = 8,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] RESET_VAL   = {DATA_W{1'b0}}
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic              spi_cs,
    input  logic              spi_sclk,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic              wr_strobe,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              frame_abort,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic              host_we,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata
);

    localparam int CMD_LEN = 1 + ADDR_W;
    localparam int FL      = CMD_LEN + DATA_W;
    localparam int BCNT_W  = $clog2(FL + 1);
    localparam int DEPTH   = 2 ** ADDR_W;

    localparam logic [BCNT_W-1:0] CMD_LEN_C = BCNT_W'(CMD_LEN);
    localparam logic [BCNT_W-1:0] FL_C      = BCNT_W'(FL);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    // synchronizers and edge-detect flops
    logic [SYNC_STAGES-1:0] cs_sync_r;
    logic [SYNC_STAGES-1:0] sclk_sync_r;
    logic [SYNC_STAGES-1:0] mosi_sync_r;
    logic                   cs_d_r;
    logic                   sclk_d_r;

    logic cs_s, sclk_s, mosi_s;
    logic sclk_rise_s, sclk_fall_s, cs_fall_s, cs_rise_s;

    // frame engine
    state_t              state_r;
    logic [BCNT_W-1:0]   bcnt_r;
    logic [BCNT_W-1:0]   bcnt_next_s;
    logic [ADDR_W-1:0]   cmd_sr_r;      // the oldest command bit falls off the top
    logic [ADDR_W:0]     cmd_next_s;
    logic [DATA_W-2:0]   rx_sr_r;       // same trick for the data bits
    logic [DATA_W-1:0]   rx_next_s;
    logic [DATA_W-1:0]   tx_sr_r;
    logic                rnw_r;
    logic [ADDR_W-1:0]   addr_r;

    // registered outputs
    logic                spi_miso_r;
    logic                spi_miso_oe_r;
    logic                wr_strobe_r;
    logic [ADDR_W-1:0]   wr_addr_r;
    logic [DATA_W-1:0]   wr_data_r;
    logic                frame_abort_r;
    logic [DATA_W-1:0]   host_rdata_r;

    logic [DATA_W-1:0]   regs_r [DEPTH];

    // Pin synchronizers; idle values (CS high, SCLK low) so reset never fakes an edge.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            cs_sync_r   <= {SYNC_STAGES{1'b1}};
            sclk_sync_r <= {SYNC_STAGES{1'b0}};
            mosi_sync_r <= {SYNC_STAGES{1'b0}};
            cs_d_r      <= 1'b1;
            sclk_d_r    <= 1'b0;
        end else begin
            cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], spi_cs};
            sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], spi_sclk};
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], spi_mosi};
            cs_d_r      <= cs_sync_r[SYNC_STAGES-1];
            sclk_d_r    <= sclk_sync_r[SYNC_STAGES-1];
        end
    end

    assign cs_s        = cs_sync_r[SYNC_STAGES-1];
    assign sclk_s      = sclk_sync_r[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_r[SYNC_STAGES-1];   // travels with sclk_s, so it is stable at sclk_rise_s
    assign sclk_rise_s = sclk_s & ~sclk_d_r;
    assign sclk_fall_s = ~sclk_s & sclk_d_r;
    assign cs_fall_s   = ~cs_s & cs_d_r;
    assign cs_rise_s   = cs_s & ~cs_d_r;

    assign bcnt_next_s = bcnt_r + BCNT_W'(1);
    assign cmd_next_s  = {cmd_sr_r, mosi_s};
    assign rx_next_s   = {rx_sr_r, mosi_s};

    // Frame FSM: command/data shifting, MISO generation, commit and abort pulses.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            bcnt_r        <= {BCNT_W{1'b0}};
            cmd_sr_r      <= {ADDR_W{1'b0}};
            rx_sr_r       <= {(DATA_W-1){1'b0}};
            tx_sr_r       <= {DATA_W{1'b0}};
            rnw_r         <= 1'b0;
            addr_r        <= {ADDR_W{1'b0}};
            spi_miso_r    <= 1'b0;
            spi_miso_oe_r <= 1'b0;
            wr_strobe_r   <= 1'b0;
            wr_addr_r     <= {ADDR_W{1'b0}};
            wr_data_r     <= {DATA_W{1'b0}};
            frame_abort_r <= 1'b0;
        end else begin
            wr_strobe_r   <= 1'b0;
            frame_abort_r <= 1'b0;
            spi_miso_oe_r <= ~cs_s;
            case (state_r)
                ST_IDLE: begin
                    spi_miso_r <= 1'b0;
                    if (cs_fall_s) begin
                        state_r  <= ST_CMD;
                        bcnt_r   <= {BCNT_W{1'b0}};
                        cmd_sr_r <= {ADDR_W{1'b0}};
                        rx_sr_r  <= {(DATA_W-1){1'b0}};
                        tx_sr_r  <= {DATA_W{1'b0}};
                    end
                end
                ST_CMD: begin
                    spi_miso_r <= 1'b0;
                    if (cs_rise_s) begin
                        frame_abort_r <= 1'b1;
                        state_r       <= ST_IDLE;
                    end else if (sclk_rise_s) begin
                        bcnt_r   <= bcnt_next_s;
                        cmd_sr_r <= cmd_next_s[ADDR_W-1:0];
                        if (bcnt_next_s == CMD_LEN_C) begin
                            // Snapshot the register now; later host writes do not disturb the read-out.
                            rnw_r   <= cmd_next_s[ADDR_W];
                            addr_r  <= cmd_next_s[ADDR_W-1:0];
                            tx_sr_r <= regs_r[cmd_next_s[ADDR_W-1:0]];
                            state_r <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (cs_rise_s) begin
                        frame_abort_r <= 1'b1;
                        spi_miso_r    <= 1'b0;
                        state_r       <= ST_IDLE;
                    end else if (sclk_rise_s) begin
                        bcnt_r  <= bcnt_next_s;
                        rx_sr_r <= rx_next_s[DATA_W-2:0];
                        if (bcnt_next_s == FL_C) begin
                            if (rnw_r) begin
                                wr_strobe_r <= 1'b1;
                                wr_addr_r   <= addr_r;
                                wr_data_r   <= rx_next_s;
                            end
                            spi_miso_r <= 1'b0;
                            state_r    <= ST_HOLD;
                        end
                    end else if (sclk_fall_s) begin
                        spi_miso_r <= tx_sr_r[DATA_W-1];
                        tx_sr_r    <= {tx_sr_r[DATA_W-2:0], 1'b0};
                    end
                end
                ST_HOLD: begin
                    spi_miso_r <= 1'b0;
                    if (cs_rise_s) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    spi_miso_r <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

    // Register file: the SPI commit lands in the strobe cycle and is written last, so it wins a collision.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= RESET_VAL;
            end
        end else begin
            if (host_we) begin
                regs_r[host_addr] <= host_wdata;
            end
            if (wr_strobe_r) begin
                regs_r[wr_addr_r] <= wr_data_r;
            end
        end
    end

    // Registered host read port.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            host_rdata_r <= {DATA_W{1'b0}};
        end else begin
            host_rdata_r <= regs_r[host_addr];
        end
    end

    assign spi_miso    = spi_miso_r;
    assign spi_miso_oe = spi_miso_oe_r;
    assign wr_strobe   = wr_strobe_r;
    assign wr_addr     = wr_addr_r;
    assign wr_data     = wr_data_r;
    assign frame_abort = frame_abort_r;
    assign host_rdata  = host_rdata_r;

endmodule
